// File: rtl/peak_packetizer.sv
// Captures FFT peak-record frames and serialises them as A5 | N | N x {freq,mag,phase} | xor byte.
// Latency: header byte is valid the cycle after the completing eop when the transmitter is idle.
// Backpressure: source_ready stalls the byte stream; frames completing while busy are dropped and counted.
module peak_packetizer #(
   parameter int PEAKS      = 4,
   parameter int DROP_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sink_sop,
   input  logic                  sink_eop,
   input  logic                  sink_valid,
   input  logic [31:0]           sink_freq,
   input  logic [31:0]           sink_mag,
   input  logic [31:0]           sink_phase,
   output logic [7:0]            source_data,
   output logic                  source_valid,
   input  logic                  source_ready,
   output logic [DROP_WIDTH-1:0] drop_count
);

   localparam int NW = $clog2(PEAKS + 1);

   typedef enum logic [2:0] {IDLE, HEADER, COUNT, PAYLOAD, CHECKSUM} state_t;

   state_t                 state, state_nxt;
   logic [PEAKS-1:0][95:0] cap_buf, cap_buf_nxt, tx_buf;
   logic [NW-1:0]          n, n_nxt, tx_n, rec_idx, rec_nxt;
   logic                   in_frame, in_frame_nxt, frame_done;
   logic [3:0]             byte_idx, byte_nxt;
   logic [7:0]             chk, chk_nxt, data_nxt, sel_byte;
   logic                   valid_nxt, hs, can_load, load, use_payload;
   logic [95:0]            sel_rec;

   // Capture side: next buffer contents include the current record so a
   // completing frame can be copied straight into the transmit buffer.
   always_comb begin
      cap_buf_nxt  = cap_buf;
      n_nxt        = n;
      in_frame_nxt = in_frame;
      frame_done   = 1'b0;
      if (sink_valid) begin
         if (sink_sop) begin
            cap_buf_nxt[0] = {sink_freq, sink_mag, sink_phase};
            n_nxt          = NW'(1);
            in_frame_nxt   = !sink_eop;
            frame_done     = sink_eop;
         end else if (in_frame) begin
            if (n < NW'(PEAKS)) begin
               for (int i = 0; i < PEAKS; i++) begin
                  if (n == NW'(i)) cap_buf_nxt[i] = {sink_freq, sink_mag, sink_phase};
               end
               n_nxt = n + NW'(1);
            end
            if (sink_eop) begin
               frame_done   = 1'b1;
               in_frame_nxt = 1'b0;
            end
         end
      end
   end

   assign hs       = source_valid && source_ready;
   assign can_load = (state == IDLE) || (state == CHECKSUM && hs);
   assign load     = frame_done && can_load;

   always_comb begin
      state_nxt   = state;
      rec_nxt     = rec_idx;
      byte_nxt    = byte_idx;
      chk_nxt     = chk;
      data_nxt    = source_data;
      valid_nxt   = source_valid;
      use_payload = 1'b0;
      sel_rec     = '0;
      sel_byte    = '0;
      case (state)
         IDLE: begin
            if (load) begin
               state_nxt = HEADER;
               data_nxt  = 8'hA5;
               valid_nxt = 1'b1;
               chk_nxt   = '0;
            end
         end
         HEADER: begin
            if (hs) begin
               state_nxt = COUNT;
               data_nxt  = 8'(tx_n);
            end
         end
         COUNT: begin
            if (hs) begin
               state_nxt   = PAYLOAD;
               chk_nxt     = chk ^ source_data;
               rec_nxt     = '0;
               byte_nxt    = '0;
               use_payload = 1'b1;
            end
         end
         PAYLOAD: begin
            if (hs) begin
               chk_nxt = chk ^ source_data;
               if (byte_idx == 4'd11) begin
                  byte_nxt = '0;
                  if (rec_idx == tx_n - NW'(1)) begin
                     state_nxt = CHECKSUM;
                     data_nxt  = chk_nxt;
                  end else begin
                     rec_nxt     = rec_idx + NW'(1);
                     use_payload = 1'b1;
                  end
               end else begin
                  byte_nxt    = byte_idx + 4'd1;
                  use_payload = 1'b1;
               end
            end
         end
         CHECKSUM: begin
            if (hs) begin
               if (load) begin
                  state_nxt = HEADER;
                  data_nxt  = 8'hA5;
                  chk_nxt   = '0;
               end else begin
                  state_nxt = IDLE;
                  valid_nxt = 1'b0;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      // Next payload byte: record rec_nxt, byte byte_nxt counted MSB first.
      for (int i = 0; i < PEAKS; i++) begin
         if (rec_nxt == NW'(i)) sel_rec = tx_buf[i];
      end
      for (int b = 0; b < 12; b++) begin
         if (byte_nxt == 4'(b)) sel_byte = sel_rec[95-8*b -: 8];
      end
      if (use_payload) data_nxt = sel_byte;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         cap_buf      <= '0;
         n            <= '0;
         in_frame     <= 1'b0;
         tx_buf       <= '0;
         tx_n         <= '0;
         rec_idx      <= '0;
         byte_idx     <= '0;
         chk          <= '0;
         source_data  <= '0;
         source_valid <= 1'b0;
         drop_count   <= '0;
      end else begin
         state        <= state_nxt;
         cap_buf      <= cap_buf_nxt;
         n            <= n_nxt;
         in_frame     <= in_frame_nxt;
         rec_idx      <= rec_nxt;
         byte_idx     <= byte_nxt;
         chk          <= chk_nxt;
         source_data  <= data_nxt;
         source_valid <= valid_nxt;
         if (load) begin
            tx_buf <= cap_buf_nxt;
            tx_n   <= n_nxt;
         end
         if (frame_done && !can_load && drop_count != '1)
            drop_count <= drop_count + DROP_WIDTH'(1);
      end
   end

endmodule

// File: doc/peak_packetizer.md
# peak_packetizer

Downstream of the FFT peak detector. Captures each batch of peak records (frequency, magnitude, phase, 32-bit fixed point with 8 fractional bits) and serialises it into a framed byte stream with a valid/ready handshake, for a UART or host link. The peak detector has no backpressure input, so a frame that arrives while a transmission is in progress is dropped and counted.

## Interface
- PEAKS, 4: maximum records per frame; also the capture buffer depth.
- DROP_WIDTH, 16: width of the dropped-frame counter.

- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- sink_sop  in  1  first record of a frame.
- sink_eop  in  1  last record of a frame.
- sink_valid  in  1  record valid this cycle; no ready; never stalled.
- sink_freq  in  32  peak frequency (FP).
- sink_mag  in  32  peak magnitude (FP).
- sink_phase  in  32  peak phase in degrees (FP).
- source_data  out  8  output byte.
- source_valid  out  1  source_data valid.
- source_ready  in  1  consumer accepts the byte when high together with source_valid.
- drop_count  out  DROP_WIDTH  frames dropped since reset; saturates at all-ones.

## Operation
- Capture buffer: PEAKS records × 96 bits, plus a fill count `n` (0..PEAKS) and an `in_frame` flag.
- Records are accepted only when sink_valid=1.
  - sop: write the record to slot 0, set n=1 and in_frame=1. A sop received mid-frame discards the partial frame.
  - Non-sop while in_frame: if n<PEAKS, write to slot n and increment n. Otherwise ignore the record.
  - Valid while not in_frame and no sop: ignored.
  - eop: clear in_frame. The frame is complete with count n, including this record if it was written. sop and eop in the same cycle form a one-record frame.
- On frame completion:
  - If the transmitter can load, copy the capture buffer into the transmit buffer.
  - Otherwise leave the transmit buffer untouched and increment drop_count (saturating).
  - "Can load" means the FSM is in IDLE, or in CHECKSUM with source_valid && source_ready this cycle.
- Packet format is 3+12N bytes:
  - 0xA5 header.
  - N as one byte.
  - For each record i=0..N-1: freq, mag, phase, each 4 bytes, MSB first.
  - Checksum = XOR of the count byte and all payload bytes. The header is excluded.
- FSM states: IDLE, HEADER, COUNT, PAYLOAD, CHECKSUM.
  - IDLE → HEADER on load.
  - HEADER → COUNT on handshake.
  - COUNT → PAYLOAD on handshake.
  - PAYLOAD steps a byte index 0..12N-1 on each handshake. It moves to CHECKSUM after the handshake at index 12N-1.
  - CHECKSUM → HEADER on handshake if a load happens in that cycle, else → IDLE.
- Checksum accumulates on each accepted count or payload byte and is cleared on load.
- source_data is a registered function of state, index and transmit buffer.
- source_data and source_valid hold stable while source_valid=1 and source_ready=0.

## Timing
- Reset values: source_valid=0, source_data=0x00, drop_count=0, FSM=IDLE, n=0, in_frame=0, checksum=0.
- Reset asserted mid-packet aborts it immediately. Partial bytes are never resumed.
- Latency: with eop sampled at edge E and the FSM idle, source_valid=1 with 0xA5 from E+1.
- With source_ready held high, one byte is transferred per cycle with no bubbles. A packet of N records occupies 3+12N consecutive cycles.
- Back-to-back: when eop coincides with the checksum handshake, the next header follows in the next cycle.
- Capture continues during transmission. Only frame completion interacts with the transmitter.
- source_valid never drops without a handshake, except on reset.

## Test plan
- One record (freq=0x00000100, mag=0x00001200, phase=0xFFFFA600), sop=eop=1, source_ready=1 → bytes A5 01 00 00 01 00 00 00 12 00 FF FF A6 00 B4 on 15 consecutive cycles starting one cycle after the input.
- Four-record frame with source_ready toggling 1/0 each cycle → 51 bytes, correct order and checksum; data held stable during every stall.
- Frame of 6 records with PEAKS=4 → count byte 04, records 0..3 only. Stray sink_valid without sop before the frame → no effect.
- Second frame's eop arrives while the first packet is in PAYLOAD → first packet completes unchanged, drop_count=1, no second packet. Repeat with the eop on the checksum handshake → no drop; second header arrives the next cycle.
- Assert reset during PAYLOAD byte 5 → source_valid=0 and drop_count=0 in the same cycle. A following frame transmits a complete, correct packet.
- sop mid-frame after 2 records, then 1 record with eop → count byte 02 containing only the post-restart records.
